// File: rtl/signed_add_arbiter_pkg.sv
// Shared constants and helpers for the shared signed adder / arbiter block.
//   ADD_ARB_MAX_REQ : largest supported requester count.
//   clog2_min1(n)   : ceil(log2(n)), never less than 1, used to size the
//                     requester tag and round-robin pointer.
package signed_add_arbiter_pkg;

  localparam int ADD_ARB_MAX_REQ = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/signed_add_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req          : request bit per requester.
//   pointer      : highest-priority index for this cycle.
//   grant_onehot : one-hot grant (zero when no request).
//   grant_idx    : index of the granted requester (0 when no request).
//   any          : at least one request is asserted.
module rr_arbiter
  import signed_add_arbiter_pkg::*;
#(
  parameter  int G_NUM_REQ  = 4,
  localparam int G_ID_WIDTH = clog2_min1(G_NUM_REQ)
) (
  input  logic [G_NUM_REQ-1:0]  req,
  input  logic [G_ID_WIDTH-1:0] pointer,
  output logic [G_NUM_REQ-1:0]  grant_onehot,
  output logic [G_ID_WIDTH-1:0] grant_idx,
  output logic                  any
);

  logic [G_NUM_REQ-1:0] upper_mask;
  logic [G_NUM_REQ-1:0] masked_req;
  logic [G_NUM_REQ-1:0] search_req;

  // Requests at or above the pointer win first; if none, the wrapped search
  // reduces to a plain lowest-index pick over all requests.
  genvar gi;
  generate
    for (gi = 0; gi < G_NUM_REQ; gi++) begin : g_mask
      assign upper_mask[gi] = (G_ID_WIDTH'(gi) >= pointer);
    end
  endgenerate

  assign masked_req = req & upper_mask;
  assign search_req = (|masked_req) ? masked_req : req;
  assign any        = |req;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    // Descending scan so the lowest set index is the one left standing.
    for (int k = G_NUM_REQ - 1; k >= 0; k--) begin
      if (search_req[k]) begin
        grant_onehot    = '0;
        grant_onehot[k] = 1'b1;
        grant_idx       = G_ID_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/signed_add_arbiter.sv
// One registered signed adder (c = a + b, one bit of growth) shared by
// G_NUM_REQ requesters through a round-robin arbiter.
//   clk, rst_n           : clock, asynchronous active-low reset.
//   req_valid/req_ready  : per-requester handshake; req_ready is one-hot or 0.
//   req_a/req_b          : packed operand pairs, requester i at [i*W +: W].
//   res_valid/res_ready  : result handshake, one register deep.
//   res_c                : sign-extended sum, G_IN_WIDTH+1 bits.
//   res_id               : index of the requester that produced res_c.
module signed_add_arbiter
  import signed_add_arbiter_pkg::*;
#(
  parameter  int G_NUM_REQ  = 4,
  parameter  int G_IN_WIDTH = 18,
  localparam int G_ID_WIDTH = clog2_min1(G_NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [G_NUM_REQ-1:0]            req_valid,
  output logic [G_NUM_REQ-1:0]            req_ready,
  input  logic [G_NUM_REQ*G_IN_WIDTH-1:0] req_a,
  input  logic [G_NUM_REQ*G_IN_WIDTH-1:0] req_b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [G_IN_WIDTH:0]             res_c,
  output logic [G_ID_WIDTH-1:0]           res_id
);

  localparam logic [G_ID_WIDTH-1:0] LAST_IDX = G_ID_WIDTH'(G_NUM_REQ - 1);

  logic                  res_valid_q, res_valid_d;
  logic [G_IN_WIDTH:0]   res_c_q, res_c_d;
  logic [G_ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [G_ID_WIDTH-1:0] ptr_q, ptr_d;

  logic [G_NUM_REQ-1:0]  grant_onehot;
  logic [G_ID_WIDTH-1:0] grant_idx;
  logic                  grant_any;
  logic                  can_accept;
  logic                  xfer;
  logic [G_IN_WIDTH-1:0] a_arr [G_NUM_REQ];
  logic [G_IN_WIDTH-1:0] b_arr [G_NUM_REQ];
  logic [G_IN_WIDTH-1:0] a_sel, b_sel;
  logic [G_IN_WIDTH:0]   sum;

  genvar gi;
  generate
    for (gi = 0; gi < G_NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*G_IN_WIDTH +: G_IN_WIDTH];
      assign b_arr[gi] = req_b[gi*G_IN_WIDTH +: G_IN_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .G_NUM_REQ(G_NUM_REQ)
  ) u_arb (
    .req          (req_valid),
    .pointer      (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  assign can_accept = !res_valid_q || res_ready;
  assign xfer       = grant_any && can_accept;

  // rst_n gates req_ready directly so it falls the moment reset asserts,
  // not at the next edge (the cleared output stage would otherwise look free).
  assign req_ready = grant_onehot & {G_NUM_REQ{can_accept && rst_n}};

  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];
  assign sum   = {a_sel[G_IN_WIDTH-1], a_sel} + {b_sel[G_IN_WIDTH-1], b_sel};

  always_comb begin
    res_valid_d = res_valid_q;
    res_c_d     = res_c_q;
    res_id_d    = res_id_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_c_d     = sum;
      res_id_d    = grant_idx;
      ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      res_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      res_id_q    <= res_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_c     = res_c_q;
  assign res_id    = res_id_q;

endmodule

// File: doc/signed_add_arbiter.md
Name: signed_add_arbiter

Overview:
- Shares one registered signed adder (c = a + b, one bit of growth) between G_NUM_REQ requesters in the neural-network datapath.
- Each requester presents an (a, b) operand pair with a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The sum is returned on a single output channel, tagged with the requester index, with valid/ready backpressure.
- Typical users: partial-sum producers in a neuron that cannot each afford a private adder.

Parameters:
- G_NUM_REQ, 4, number of requesters (2..16).
- G_IN_WIDTH, 18, operand width in bits (two's complement).
- G_ID_WIDTH, $clog2(G_NUM_REQ) (minimum 1), width of the requester tag (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active low.
- req_valid  input  G_NUM_REQ  per-requester operand valid.
- req_ready  output  G_NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  G_NUM_REQ x G_IN_WIDTH  signed operand a per requester.
- req_b  input  G_NUM_REQ x G_IN_WIDTH  signed operand b per requester.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accept.
- res_c  output  G_IN_WIDTH+1  signed sum.
- res_id  output  G_ID_WIDTH  index of the requester that produced res_c.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_c=0, res_id=0, rr pointer=0, req_ready=0.
- Output stage is one register deep.
  - can_accept = !res_valid | res_ready.
- Arbitration is combinational each cycle.
  - Search req_valid starting at the rr pointer, ascending with wrap at G_NUM_REQ-1 -> 0.
  - The first asserted index is the grant g.
  - req_ready[g] = can_accept; all other bits are 0.
  - req_ready may depend on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
- Transfer on req_valid[g] & req_ready[g]. At the next clk edge:
  - res_c <= sext(req_a[g]) + sext(req_b[g]), sign-extended from bit G_IN_WIDTH-1. No overflow is possible.
  - res_id <= g, res_valid <= 1.
  - pointer <= (g+1) mod G_NUM_REQ.
- No transfer and res_ready=1: res_valid <= 0. res_c and res_id hold their last values.
- No transfer and res_ready=0: all output registers hold. The pointer holds.
- Latency: 1 cycle from accept to res_valid.
- Throughput: 1 result/cycle while res_ready=1.
- Simultaneous pop and push (res_valid=1, res_ready=1, request pending): the new result replaces the old one in the same edge, with no bubble.
- Stall (res_valid=1, res_ready=0): all req_ready=0. Output values are stable until accepted.
- No requests: pointer unchanged, req_ready all 0.
- Fairness: any requester holding req_valid high is granted within G_NUM_REQ accepts.
- Requesters must hold req_a, req_b and req_valid stable until their handshake completes. The block does not latch operands before grant.
- Reset mid-operation: a pending result is discarded, the pointer returns to 0, and req_ready drops immediately (asynchronously).

Decomposition:
- math_pack additions:
  - constant ADD_ARB_MAX_REQ = 16.
  - function clog2_min1(n).
  - The adder itself uses signed_add_t LOGIC semantics computed inline with full-width sign extension.
- Sub-module rr_arbiter (G_NUM_REQ): inputs req, pointer; outputs grant_onehot, grant_idx, any.
- The top level holds the pointer, the output register and the handshake logic.

Test Plan:
- Single requester, W=18: req0 a=131071, b=1, res_ready=1 -> next cycle res_valid=1, res_c=131072, res_id=0. Also a=-131072, b=-1 -> res_c=-131073.
- All 4 valid every cycle, res_ready=1:
  - Grants cycle 0,1,2,3,0.
  - res_id sequence 0,1,2,3,0 with one result per cycle.
  - Each sum matches its requester's operands.
- Backpressure: result pending, res_ready=0 for 3 cycles -> req_ready=0, res_c/res_id stable. On res_ready=1, the next grant is accepted that cycle and its result appears the following cycle.
- Wrap/pointer: after grant to 2, only req1 and req3 valid -> grant 3, then 1. Sparse, gapped requests leave the pointer unchanged.
- Reset mid-stream: assert rst_n=0 while res_valid=1 -> res_valid, res_c, res_id and req_ready read 0 immediately. After release, the first grant starts from index 0.
- Random regression:
  - 10k cycles, random valid/ready/operands.
  - A scoreboard checks every sum and id.
  - Checks no lost or duplicated transfers.
  - Checks starvation bound ≤ G_NUM_REQ accepts.
